// File: rtl/prod_accum.sv
// ---------------------------------------------------------------------------
// prod_accum
//   Multiply-accumulate back end for the 4x4 multiplier. A run is opened by a
//   start pulse while idle. The block then accepts exactly N_TERMS unsigned
//   products and adds them into an AW-bit accumulator. The final sum is
//   presented on a valid/ready output port.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous, active-low reset
//   start      in   1   begin a new run (only looked at in IDLE)
//   in_valid   in   1   prod is valid this cycle
//   in_ready   out  1   block can take prod this cycle (high in ACC)
//   prod       in   PW  unsigned product from the multiplier
//   sum        out  AW  accumulated result (always the registered acc)
//   out_valid  out  1   sum is final and held (high in DONE)
//   out_ready  in   1   consumer accepts sum
//   busy       out  1   high in ACC or DONE
//   ovf        out  1   sticky carry out of bit AW-1 during this run
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its data until that edge.
// Ready never depends combinationally on valid in this block.
// ---------------------------------------------------------------------------
module prod_accum #(
    parameter int PW      = 8,
    parameter int AW      = 12,   // must be >= PW
    parameter int N_TERMS = 4     // 1..255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] prod,
    output logic [AW-1:0] sum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(N_TERMS - 1);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] acc;
    logic [7:0]    cnt;
    logic          xfer;
    logic          last_term;
    logic [AW:0]   add_full;   // one extra bit to capture the carry out

    assign xfer      = in_valid & in_ready;
    assign last_term = (cnt == CNT_LAST);
    assign add_full  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, prod};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (xfer && last_term) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // start is ignored here, even alongside out_ready
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath. acc is cleared only at start, so sum keeps the last result
    // through IDLE until the next run begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == ACC && xfer) begin
            acc <= add_full[AW-1:0];
            ovf <= ovf | add_full[AW];
            cnt <= cnt + 8'd1;
        end
    end

    assign sum  = acc;
    assign busy = (state != IDLE);

endmodule
